// File: rtl/elevator_car_model.sv
// elevator_car_model: two-floor car/shaft/hall-button plant with position tracking and sticky fault detection
module elevator_car_model #(
    parameter int TRAVEL_CYCLES = 8,
    parameter int OVERRUN_MAX   = 2,
    parameter int CNT_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn1,
    input  logic             btn2,
    input  logic             motor_up,
    input  logic             motor_down,
    input  logic             door_open,
    output logic             call1,
    output logic             call2,
    output logic             floor_sensor,
    output logic [CNT_W-1:0] position,
    output logic             in_motion,
    output logic             fault,
    output logic [1:0]       fault_code
);
    localparam logic [CNT_W-1:0] TOP    = CNT_W'(TRAVEL_CYCLES);
    localparam int               OV_W   = $clog2(OVERRUN_MAX + 2);
    localparam logic [OV_W-1:0]  OV_LIM = OV_W'(OVERRUN_MAX);
    localparam logic [OV_W-1:0]  OV_SAT = OV_W'(OVERRUN_MAX + 1);

    logic [CNT_W-1:0] r_position;
    logic [OV_W-1:0]  r_overrun;
    logic             r_floor;
    logic             r_call1;
    logic             r_call2;
    logic             r_fault;
    logic [1:0]       r_fault_code;

    logic             w_at_bot;
    logic             w_at_top;
    logic             w_in_motion;
    logic             w_conflict;
    logic             w_interlock;
    logic             w_overdrive;
    logic             w_overrun;
    logic             w_viol;
    logic             w_halt;
    logic             w_serve1;
    logic             w_serve2;
    logic             w_clr1;
    logic             w_clr2;
    logic [1:0]       w_code;
    logic [CNT_W-1:0] w_pos_next;

    assign w_at_bot    = r_position == '0;
    assign w_at_top    = r_position == TOP;
    assign w_in_motion = !w_at_bot && !w_at_top;
    assign w_conflict  = motor_up && motor_down;
    assign w_interlock = door_open && (w_in_motion || motor_up || motor_down);
    assign w_overdrive = (motor_up && w_at_top) || (motor_down && w_at_bot);
    assign w_overrun   = w_overdrive && (r_overrun >= OV_LIM);
    assign w_viol      = w_conflict || w_interlock || w_overrun;
    // The edge that raises a fault already freezes the car and drops the calls.
    assign w_halt      = r_fault || w_viol;
    assign w_code      = w_conflict ? 2'b10 : w_interlock ? 2'b11 : 2'b01;
    assign w_serve1    = w_at_bot && (!(motor_up || motor_down) || door_open);
    assign w_serve2    = w_at_top && (!(motor_up || motor_down) || door_open);
    assign w_clr1      = door_open && w_at_bot;
    assign w_clr2      = door_open && w_at_top;
    assign w_pos_next  = (motor_up && !motor_down && !w_at_top) ? r_position + 1'b1 :
                         (motor_down && !motor_up && !w_at_bot) ? r_position - 1'b1 : r_position;

    assign call1        = r_call1;
    assign call2        = r_call2;
    assign floor_sensor = r_floor;
    assign position     = r_position;
    assign in_motion    = w_in_motion;
    assign fault        = r_fault;
    assign fault_code   = r_fault_code;

    // Car position, floor sensor, hall calls, end-stop overrun count and sticky fault.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_position   <= '0;
            r_overrun    <= '0;
            r_floor      <= 1'b0;
            r_call1      <= 1'b0;
            r_call2      <= 1'b0;
            r_fault      <= 1'b0;
            r_fault_code <= 2'b00;
        end else begin
            r_overrun <= !w_overdrive ? '0 : (r_overrun == OV_SAT) ? r_overrun : r_overrun + 1'b1;
            if (!r_fault && w_viol) begin
                r_fault      <= 1'b1;
                r_fault_code <= w_code;
            end
            if (w_halt) begin
                r_call1 <= 1'b0;
                r_call2 <= 1'b0;
            end else begin
                r_position <= w_pos_next;
                r_floor    <= (w_pos_next == TOP) ? 1'b1 : (w_pos_next == '0) ? 1'b0 : r_floor;
                r_call1    <= w_clr1 ? 1'b0 : (btn1 && !w_serve1) || r_call1;
                r_call2    <= w_clr2 ? 1'b0 : (btn2 && !w_serve2) || r_call2;
            end
        end
    end
endmodule

// File: tb/tb_elevator_car_model.sv
// tb_elevator_car_model: scoreboard bench for the elevator car plant
module tb_elevator_car_model;
    localparam int T  = 8;
    localparam int OM = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn1 = 1'b0, btn2 = 1'b0, motor_up = 1'b0, motor_down = 1'b0, door_open = 1'b0;
    logic       call1, call2, floor_sensor, in_motion, fault;
    logic [3:0] position;
    logic [1:0] fault_code;

    int checks = 0;
    int errors = 0;

    logic [10:0] sb_q[$];
    string       tag_q[$];

    int m_pos, m_ov, m_code;
    bit m_fl, m_c1, m_c2, m_f;

    elevator_car_model #(.TRAVEL_CYCLES(T), .OVERRUN_MAX(OM), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .btn1(btn1), .btn2(btn2),
        .motor_up(motor_up), .motor_down(motor_down), .door_open(door_open),
        .call1(call1), .call2(call2), .floor_sensor(floor_sensor), .position(position),
        .in_motion(in_motion), .fault(fault), .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] got();
        return {call1, call2, floor_sensor, position, in_motion, fault, fault_code};
    endfunction

    function automatic logic [10:0] model_vec();
        bit in_m;
        in_m = m_pos > 0 && m_pos < T;
        return {m_c1, m_c2, m_fl, 4'(m_pos), in_m, m_f, 2'(m_code)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_pos = 0; m_ov = 0; m_code = 0; m_fl = 0; m_c1 = 0; m_c2 = 0; m_f = 0;
    endtask

    task automatic m_step(input bit b1, b2, up, dn, dr);
        bit in_m, conf, intl, od, ovr, s1, s2;
        in_m = m_pos > 0 && m_pos < T;
        conf = up && dn;
        intl = dr && (in_m || up || dn);
        od   = (up && m_pos == T) || (dn && m_pos == 0);
        ovr  = od && m_ov >= OM;
        m_ov = od ? m_ov + 1 : 0;
        if (!m_f && (conf || intl || ovr)) begin
            m_f = 1;
            m_code = conf ? 2 : intl ? 3 : 1;
        end
        if (m_f) begin
            m_c1 = 0;
            m_c2 = 0;
        end else begin
            s1 = m_pos == 0 && (!(up || dn) || dr);
            s2 = m_pos == T && (!(up || dn) || dr);
            if (dr && m_pos == 0) m_c1 = 0; else if (b1 && !s1) m_c1 = 1;
            if (dr && m_pos == T) m_c2 = 0; else if (b2 && !s2) m_c2 = 1;
            if (up && !dn && m_pos < T) m_pos++;
            else if (dn && !up && m_pos > 0) m_pos--;
            if (m_pos == T) m_fl = 1; else if (m_pos == 0) m_fl = 0;
        end
    endtask

    task automatic cyc(input bit b1, b2, up, dn, dr, input string tag);
        btn1 = b1; btn2 = b2; motor_up = up; motor_down = dn; door_open = dr;
        m_step(b1, b2, up, dn, dr);
        sb_q.push_back(model_vec());
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        chk(tag_q.pop_front(), 32'(got()), 32'(sb_q.pop_front()));
    endtask

    task automatic do_reset();
        btn1 = 0; btn2 = 0; motor_up = 0; motor_down = 0; door_open = 0;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_vec", 32'(got()), 32'h0);
        chk("async_rst_pos", 32'(position), 32'h0);
        m_reset();
        @(negedge clk) rst = 1'b0;
    endtask

    initial begin
        m_reset();
        #12;
        chk("rst_vec", 32'(got()), 32'h0);
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 0, "mid_up");
        chk("mid_pos5", 32'(position), 32'd5);
        do_reset();
        cyc(0, 1, 0, 0, 0, "btn2");
        chk("call2_set", 32'(call2), 32'd1);
        for (int i = 0; i < T; i++) cyc(0, 0, 1, 0, 0, "up");
        chk("floor2_sensor", 32'(floor_sensor), 32'd1);
        cyc(0, 0, 1, 0, 0, "up_extra");
        chk("no_fault_extra", 32'(fault), 32'd0);
        cyc(0, 0, 0, 0, 1, "door2");
        chk("call2_clr", 32'(call2), 32'd0);
        cyc(1, 0, 0, 0, 0, "btn1");
        for (int i = 0; i < T; i++) cyc(0, 0, 0, 1, 0, "down");
        chk("floor1_sensor", 32'(floor_sensor), 32'd0);
        cyc(0, 0, 0, 0, 1, "door1");
        chk("call1_clr", 32'(call1), 32'd0);
        cyc(1, 1, 0, 0, 0, "both_btn");
        chk("call1_ignored", 32'(call1), 32'd0);
        chk("call2_latched", 32'(call2), 32'd1);
        for (int i = 0; i < T; i++) cyc(0, 0, 1, 0, 0, "up_b");
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, "overrun");
        chk("overrun_code", 32'({fault, fault_code}), 32'b101);
        cyc(1, 0, 0, 0, 0, "btn1_in_fault");
        cyc(0, 0, 0, 1, 0, "down_in_fault");
        chk("frozen_pos8", 32'(position), 32'd8);
        do_reset();
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, "up_c");
        cyc(0, 0, 1, 1, 0, "conflict");
        chk("conflict_code", 32'({fault, fault_code, position}), 32'({3'b110, 4'd3}));
        do_reset();
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0, "up_d");
        cyc(0, 0, 0, 0, 1, "door_moving");
        chk("interlock_code", 32'(fault_code), 32'b11);
        cyc(0, 0, 1, 1, 0, "conflict_after");
        do_reset();
        cyc(0, 0, 1, 1, 1, "prio_conf");
        do_reset();
        cyc(0, 0, 1, 0, 1, "door_motor");
        do_reset();
        cyc(0, 0, 0, 1, 0, "down_at_0_a");
        cyc(0, 0, 0, 1, 0, "down_at_0_b");
        cyc(0, 0, 0, 0, 0, "idle_clear_ov");
        cyc(0, 0, 0, 1, 0, "down_at_0_c");
        cyc(0, 0, 0, 1, 0, "down_at_0_d");
        cyc(0, 0, 0, 1, 0, "down_at_0_e");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
